wb_trace_buf: RTL and testbench
===============================

WB_TRACE_BUF -- requirements
Module: wb_trace_buf

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter SEQ_W, default 16, sequence-number width.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 trace_en  input  1  capture enable.
REQ-006 clear  input  1  synchronous flush of FIFO and counters.
REQ-007 wb_have_inst  input  1  core commits an instruction this cycle (debug_wb_have_inst).
REQ-008 wb_pc  input  32  committed PC.
REQ-009 wb_ena  input  1  register-file write enable of the commit.
REQ-010 wb_reg  input  5  destination register.
REQ-011 wb_value  input  32  write-back value.
REQ-012 trace_valid  output  1  record available.
REQ-013 trace_ready  input  1  consumer accepts the record.
REQ-014 trace_data  output  SEQ_W+71  record {seq, gap, ena, reg[4:0], pc[31:0], value[31:0]}, MSB first.
REQ-015 level  output  log2(DEPTH)+1  occupied entries.
REQ-016 overflow  output  1  sticky; at least one commit dropped.
REQ-017 drop_cnt  output  16  saturating count of dropped commits.

Function
REQ-018 Capture event = trace_en & wb_have_inst & ~clear.
REQ-019 Each capture event SHALL take the current seq counter value, then increment it modulo 2^SEQ_W, whether the record is accepted or dropped.
REQ-020 pop = trace_valid & trace_ready; push SHALL be accepted when level < DEPTH or pop is asserted in the same cycle.
REQ-021 A capture event that is not accepted SHALL be dropped: drop_cnt increments, saturating at 0xFFFF; overflow sets; gap_pending sets.
REQ-022 An accepted record SHALL carry gap = gap_pending; gap_pending clears on that accept.
REQ-023 When wb_ena = 0, the record SHALL store reg = 0 and value = 0. Such commits (stores, branches) are still captured.
REQ-024 Latency: a record accepted at edge N SHALL present on trace_valid/trace_data after edge N, with no same-cycle bypass.
REQ-025 FIFO order SHALL be strict; trace_data SHALL stay stable while trace_valid & ~trace_ready.
REQ-026 When empty, trace_valid = 0 and trace_data is don't-care.
REQ-027 level SHALL change by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-028 clear SHALL empty the FIFO and zero seq, drop_cnt, overflow and gap_pending; it dominates a simultaneous push or pop, and the commit is not counted.
REQ-029 The read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by level or an extra pointer bit.

Reset
REQ-030 On rst, the block SHALL set trace_valid = 0, level = 0, overflow = 0, drop_cnt = 0, seq = 0 and gap_pending = 0; FIFO contents need not be reset.
REQ-031 rst SHALL dominate clear, trace_en and a pending handshake; a reset mid-drain discards all records.

Structure
REQ-032 The shared package SHALL hold the record field widths and offsets, TRACE_W = SEQ_W+71 and the drop_cnt width.
REQ-033 Storage SHALL be one sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/level); capture, sequencing and drop logic live in wb_trace_buf.

Verification
REQ-034 After rst, commit pc=0x00000004, reg=5, value=0x12, ena=1 with trace_ready=1 -> next cycle trace_valid=1 with seq=0, gap=0, ena=1, reg=5, pc=0x4, value=0x12; then level=0.
REQ-035 DEPTH=16, trace_ready=0, 20 back-to-back commits -> level=16, overflow=1, drop_cnt=4; draining yields seq 0..15, and the next commit yields seq=20, gap=1.
REQ-036 Full FIFO with pop and commit in the same cycle -> commit accepted, level stays 16, drop_cnt unchanged.
REQ-037 Commit with ena=0, reg=7, value=0xDEADBEEF -> record ena=0, reg=0, value=0, PC preserved.
REQ-038 trace_en=0 during 5 commits -> no records, seq unchanged; with trace_valid=1 and trace_ready=0 held, trace_data stays constant.
REQ-039 3 entries queued, clear asserted with a same-cycle commit -> level=0, trace_valid=0, drop_cnt=0; the following commit yields seq=0.

Source files
------------

// File: rtl/wb_trace_buf_pkg.sv
// Shared layout of a write-back trace record: field widths, bit offsets and counter widths.
package wb_trace_buf_pkg;
  localparam int VALUE_W       = 32;
  localparam int PC_W          = 32;
  localparam int REG_W         = 5;
  localparam int VALUE_LSB     = 0;
  localparam int PC_LSB        = 32;
  localparam int REG_LSB       = 64;
  localparam int ENA_BIT       = 69;
  localparam int GAP_BIT       = 70;
  localparam int SEQ_LSB       = 71;
  localparam int REC_FIXED_W   = 71;
  localparam int DROP_W        = 16;
  localparam int SEQ_W_DEFAULT = 16;
  localparam int TRACE_W       = SEQ_W_DEFAULT + REC_FIXED_W;

  function automatic int trace_w(input int seq_w);
    return seq_w + REC_FIXED_W;
  endfunction
endpackage

// File: rtl/wb_trace_buf_sync_fifo.sv
// Register-array FIFO with a flush input; a push is refused when full unless a pop happens in the same cycle.
// Data written at an edge becomes visible on rdata_o only after that edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/wb_trace_buf.sv
// Captures committed instructions into a sequenced trace FIFO, counting and flagging commits lost to a full buffer.
// Records appear one cycle after capture; consumer backpressure holds the head record stable.
module wb_trace_buf
  import wb_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int TW    = SEQ_W + REC_FIXED_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_en,
  input  logic              clear,
  input  logic              wb_have_inst,
  input  logic [31:0]       wb_pc,
  input  logic              wb_ena,
  input  logic [4:0]        wb_reg,
  input  logic [31:0]       wb_value,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [TW-1:0]     trace_data,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d, gap_q, gap_d;
  logic              fifo_full, fifo_empty, pop, cap, accept, drop;
  logic [TW-1:0]     rec;

  assign trace_valid = ~fifo_empty;
  assign pop         = trace_valid & trace_ready;
  assign cap         = trace_en & wb_have_inst & ~clear;
  assign accept      = cap & (~fifo_full | pop);
  assign drop        = cap & ~accept;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;

  // Non-writing commits are recorded with register and value zeroed.
  always_comb begin
    rec = '0;
    rec[SEQ_LSB +: SEQ_W]     = seq_q;
    rec[GAP_BIT]              = gap_q;
    rec[ENA_BIT]              = wb_ena;
    rec[PC_LSB +: PC_W]       = wb_pc;
    if (wb_ena) begin
      rec[REG_LSB +: REG_W]     = wb_reg;
      rec[VALUE_LSB +: VALUE_W] = wb_value;
    end
  end

  always_comb begin
    seq_d  = seq_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    gap_d  = gap_q;
    if (cap) seq_d = seq_q + SEQ_W'(1);
    if (accept) gap_d = 1'b0;
    if (drop) begin
      gap_d = 1'b1;
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
    if (clear) begin
      seq_d  = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
      gap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
      gap_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      gap_q  <= gap_d;
    end
  end

  sync_fifo #(.WIDTH(TW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (clear),
    .push_i  (accept),
    .wdata_i (rec),
    .pop_i   (pop),
    .rdata_o (trace_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );
endmodule

// File: tb/tb_wb_trace_buf.sv
// Directed bench for wb_trace_buf: a queue-based model checked every cycle, plus literal expectations per scenario.
module tb_wb_trace_buf;
  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;
  localparam int TW    = SEQ_W + 71;

  logic          clk = 0;
  logic          rst, trace_en, clear, wb_have_inst, wb_ena, trace_ready;
  logic [31:0]   wb_pc, wb_value;
  logic [4:0]    wb_reg;
  logic          trace_valid, overflow;
  logic [TW-1:0] trace_data;
  logic [4:0]    level;
  logic [15:0]   drop_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  always #5 clk = ~clk;

  wb_trace_buf #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .clear(clear),
    .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
    .wb_reg(wb_reg), .wb_value(wb_value), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of records plus the sideband counters.
  logic [TW-1:0] m_q[$];
  logic [15:0]   m_seq, m_drop;
  bit            m_ovf, m_gap;

  always @(posedge clk) begin
    if (rst || clear) begin
      m_q.delete();
      m_seq = 0; m_drop = 0; m_ovf = 0; m_gap = 0;
    end else begin
      bit do_pop;
      do_pop = (m_q.size() != 0) && trace_ready;
      if (do_pop) void'(m_q.pop_front());
      if (trace_en && wb_have_inst) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({m_seq, m_gap, wb_ena, wb_ena ? wb_reg : 5'd0, wb_pc, wb_ena ? wb_value : 32'd0});
          m_gap = 0;
        end else begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
          m_ovf = 1;
          m_gap = 1;
        end
        m_seq = m_seq + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", trace_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("data", trace_data, m_q[0]);
      chk("level", level, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v, input logic ena);
    wb_have_inst = 1; wb_pc = pc; wb_reg = r; wb_value = v; wb_ena = ena;
    @(negedge clk);
    wb_have_inst = 0;
  endtask

  initial begin
    rst = 1; trace_en = 0; clear = 0; wb_have_inst = 0; wb_ena = 0;
    wb_pc = 0; wb_reg = 0; wb_value = 0; trace_ready = 0;
    step(2);
    rst = 0;
    started = 1;
    chk("rst_level", level, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);

    // First record, consumer ready.
    trace_en = 1; trace_ready = 1;
    commit(32'h4, 5'd5, 32'h12, 1);
    chk("first_valid", trace_valid, 1);
    chk("first_rec", trace_data, {16'd0, 1'b0, 1'b1, 5'd5, 32'h4, 32'h12});
    step(1);
    chk("first_drained", level, 0);

    // Non-writing commit zeroes reg/value.
    trace_ready = 0;
    commit(32'h100, 5'd7, 32'hDEADBEEF, 0);
    chk("noena_rec", trace_data, {16'd1, 1'b0, 1'b0, 5'd0, 32'h100, 32'h0});
    trace_ready = 1; step(1); trace_ready = 0;
    chk("noena_drained", level, 0);

    // Disabled capture, then stability under backpressure.
    trace_en = 0;
    repeat (5) commit(32'h300, 5'd1, 32'h1, 1);
    chk("dis_level", level, 0);
    chk("dis_valid", trace_valid, 0);
    trace_en = 1;
    commit(32'h200, 5'd3, 32'hAA, 1);
    step(3);
    chk("stall_rec", trace_data, {16'd2, 1'b0, 1'b1, 5'd3, 32'h200, 32'hAA});
    trace_ready = 1; step(1); trace_ready = 0;

    clear = 1; step(1); clear = 0;

    // Overflow: 20 commits into 16 entries.
    for (int i = 0; i < 20; i++) commit(32'h1000 + 4 * i, 5'(i), 32'(i), 1);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 4);
    trace_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", trace_data[TW-1 -: 16], 16'(i));
      step(1);
    end
    trace_ready = 0;
    chk("drained_level", level, 0);
    commit(32'h2000, 5'd1, 32'h1, 1);
    chk("gap_seq", trace_data[TW-1 -: 16], 16'd20);
    chk("gap_bit", trace_data[70], 1);

    // Full with simultaneous pop and commit.
    for (int i = 0; i < 15; i++) commit(32'h3000 + 4 * i, 5'd2, 32'(i), 1);
    chk("full_level", level, 16);
    trace_ready = 1;
    commit(32'h4000, 5'd4, 32'h44, 1);
    trace_ready = 0;
    chk("fullpop_level", level, 16);
    chk("fullpop_drop", drop_cnt, 4);

    // Clear with a same-cycle commit.
    clear = 1; step(1); clear = 0;
    repeat (3) commit(32'h5000, 5'd6, 32'h66, 1);
    chk("pre_clear_level", level, 3);
    clear = 1;
    commit(32'h6000, 5'd6, 32'h66, 1);
    clear = 0;
    chk("clear_level", level, 0);
    chk("clear_valid", trace_valid, 0);
    chk("clear_drop", drop_cnt, 0);
    commit(32'h7000, 5'd8, 32'h88, 1);
    chk("clear_seq", trace_data[TW-1 -: 16], 16'd0);

    // Reset mid-drain discards everything.
    repeat (2) commit(32'h8000, 5'd9, 32'h99, 1);
    trace_ready = 1; rst = 1;
    step(1);
    rst = 0; trace_ready = 0;
    chk("rst_mid_level", level, 0);
    chk("rst_mid_valid", trace_valid, 0);
    commit(32'h9000, 5'd10, 32'hA0, 1);
    chk("rst_mid_seq", trace_data[TW-1 -: 16], 16'd0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
